// File: rtl/key_cond_pkg.sv
// rtl/key_cond_pkg.sv - shared types and defaults for the key debounce conditioner
package key_cond_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_t;

  // 20 ms at 50 MHz
  localparam int DEBOUNCE_CYCLES_DEFAULT = 1_000_000;
  localparam int SYNC_STAGES_DEFAULT     = 2;

  // Width that holds 0..debounce_cycles without wrapping
  function automatic int cnt_width(input int debounce_cycles);
    return (debounce_cycles < 1) ? 1 : $clog2(debounce_cycles + 1);
  endfunction

endpackage

// File: rtl/key_debounce_channel.sv
// rtl/key_debounce_channel.sv - one key: synchronizer, debounce FSM and qualification counter
module key_debounce_channel
  import key_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic key_level,
  output logic key_press,
  output logic key_release
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   key_s;
  key_state_t             state;
  logic [CW-1:0]          cnt;

  // FSM only ever looks at the last synchronizer stage
  assign key_s = sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync        <= '1;
      state       <= RELEASED;
      cnt         <= '0;
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      sync        <= {sync[SYNC_STAGES-2:0], key_n};
      key_press   <= 1'b0;
      key_release <= 1'b0;
      case (state)
        RELEASED: begin
          if (!key_s) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (key_s) begin
            state <= RELEASED;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state     <= PRESSED;
            cnt       <= '0;
            key_level <= 1'b1;
            key_press <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (key_s) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (!key_s) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state       <= RELEASED;
            cnt         <= '0;
            key_level   <= 1'b0;
            key_release <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= RELEASED;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_debounce_conditioner.sv
// rtl/key_debounce_conditioner.sv - N independent debounced key channels with press/release strobes
module key_debounce_conditioner
  import key_cond_pkg::*;
#(
  parameter int N_KEYS          = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_KEYS-1:0] key_n,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release
);

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .key_n      (key_n[i]),
      .key_level  (key_level[i]),
      .key_press  (key_press[i]),
      .key_release(key_release[i])
    );
  end

endmodule
